// File: rtl/fila_arbiter_if.sv
// Handshake bundle between the FILA arbiter, its producers/consumer and the 8x8 FILA queue.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface fila_arbiter_if #(
    parameter int N_PROD = 2
);
    logic [N_PROD-1:0]   prod_req;
    logic [8*N_PROD-1:0] prod_data;
    logic [N_PROD-1:0]   prod_ack;
    logic [N_PROD-1:0]   prod_nack;
    logic                cons_req;
    logic                cons_valid;
    logic [7:0]          cons_data;
    logic                cons_empty;
    logic [7:0]          q_data_in;
    logic                q_enqueue;
    logic                q_dequeue;
    logic [7:0]          q_data_out;
    logic [3:0]          q_len;
    logic                busy;
    logic                err_timeout;

    modport slave (
        input  prod_req, prod_data, cons_req, q_data_out, q_len,
        output prod_ack, prod_nack, cons_valid, cons_data, cons_empty,
               q_data_in, q_enqueue, q_dequeue, busy, err_timeout
    );

    modport master (
        output prod_req, prod_data, cons_req, q_data_out, q_len,
        input  prod_ack, prod_nack, cons_valid, cons_data, cons_empty,
               q_data_in, q_enqueue, q_dequeue, busy, err_timeout
    );
endinterface

// File: rtl/fila_arbiter.sv
// Sequencer in front of the FILA queue: arbitrates N_PROD producers and one consumer,
// issues single-cycle enqueue/dequeue strobes and confirms each op by watching q_len.
module fila_arbiter #(
    parameter int N_PROD  = 2,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4
) (
    input logic           clock_10KHz,
    input logic           reset,
    fila_arbiter_if.slave bus
);
    localparam int PW = (N_PROD > 1) ? $clog2(N_PROD) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, ENQ_ISSUE, ENQ_WAIT, DEQ_ISSUE, DEQ_WAIT, GUARD
    } state_t;

    typedef enum logic {
        TURN_PRODUCER, TURN_CONSUMER
    } turn_t;

    state_t            state;
    turn_t             turn;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     cur;
    logic [3:0]        snap;
    logic [CW-1:0]     wait_cnt;

    logic              rr_found;
    logic [PW-1:0]     rr_winner;
    logic [PW-1:0]     rr_next;
    logic [N_PROD-1:0] win_onehot;
    logic [N_PROD-1:0] cur_onehot;
    logic [7:0]        win_data;
    logic              push_pend;
    logic              pop_pend;
    logic              grant_push;

    // Round-robin pick: scan from rr_ptr upwards first, then wrap to the low indices.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (!rr_found && i >= int'(rr_ptr) && bus.prod_req[i]) begin
                rr_found  = 1'b1;
                rr_winner = PW'(i);
            end
        end
        for (int i = 0; i < N_PROD; i++) begin
            if (!rr_found && i < int'(rr_ptr) && bus.prod_req[i]) begin
                rr_found  = 1'b1;
                rr_winner = PW'(i);
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        cur_onehot = '0;
        win_data   = '0;
        for (int i = 0; i < N_PROD; i++) begin
            win_onehot[i] = (int'(rr_winner) == i);
            cur_onehot[i] = (int'(cur) == i);
            if (int'(rr_winner) == i) begin
                win_data = bus.prod_data[8*i +: 8];
            end
        end
    end

    assign rr_next    = (int'(rr_winner) == N_PROD - 1) ? '0 : rr_winner + PW'(1);
    assign push_pend  = rr_found;
    assign pop_pend   = bus.cons_req;
    assign grant_push = push_pend && (!pop_pend || turn == TURN_PRODUCER);

    // Every pulse output defaults low each cycle, so ack/nack/valid/empty and the
    // queue strobes are high for exactly the one cycle after the edge that sets them.
    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            turn            <= TURN_PRODUCER;
            rr_ptr          <= '0;
            cur             <= '0;
            snap            <= '0;
            wait_cnt        <= '0;
            bus.prod_ack    <= '0;
            bus.prod_nack   <= '0;
            bus.cons_valid  <= 1'b0;
            bus.cons_data   <= '0;
            bus.cons_empty  <= 1'b0;
            bus.q_data_in   <= '0;
            bus.q_enqueue   <= 1'b0;
            bus.q_dequeue   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.prod_ack   <= '0;
            bus.prod_nack  <= '0;
            bus.cons_valid <= 1'b0;
            bus.cons_empty <= 1'b0;
            bus.q_enqueue  <= 1'b0;
            bus.q_dequeue  <= 1'b0;

            case (state)
                IDLE: begin
                    if (push_pend || pop_pend) begin
                        turn     <= (turn == TURN_PRODUCER) ? TURN_CONSUMER : TURN_PRODUCER;
                        bus.busy <= 1'b1;
                        if (grant_push) begin
                            rr_ptr <= rr_next;
                            cur    <= rr_winner;
                            if (bus.q_len == 4'(DEPTH)) begin
                                bus.prod_nack <= win_onehot;
                                state         <= GUARD;
                            end else begin
                                snap          <= bus.q_len;
                                bus.q_data_in <= win_data;
                                bus.q_enqueue <= 1'b1;
                                state         <= ENQ_ISSUE;
                            end
                        end else begin
                            if (bus.q_len == 4'd0) begin
                                bus.cons_empty <= 1'b1;
                                state          <= GUARD;
                            end else begin
                                snap          <= bus.q_len;
                                bus.q_dequeue <= 1'b1;
                                state         <= DEQ_ISSUE;
                            end
                        end
                    end
                end

                ENQ_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ENQ_WAIT;
                end

                ENQ_WAIT: begin
                    if (bus.q_len == snap + 4'd1) begin
                        bus.prod_ack <= cur_onehot;
                        state        <= GUARD;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        bus.err_timeout <= 1'b1;
                        bus.prod_nack   <= cur_onehot;
                        state           <= GUARD;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end

                DEQ_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= DEQ_WAIT;
                end

                DEQ_WAIT: begin
                    if (bus.q_len == snap - 4'd1) begin
                        bus.cons_data  <= bus.q_data_out;
                        bus.cons_valid <= 1'b1;
                        state          <= GUARD;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        bus.err_timeout <= 1'b1;
                        bus.cons_empty  <= 1'b1;
                        state           <= GUARD;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end

                GUARD: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
